cpu_bus_arbiter: RTL
====================

# cpu_bus_arbiter

Two-to-one memory arbiter between the CPU's instruction and data ports and a single shared memory bus. It sits directly downstream of the `cpu` top level. It accepts level-held requests from both ports, grants one at a time with alternating priority, and issues a registered transaction on the memory bus. It then returns a one-cycle registered ready pulse, with read data, to the originating port.

## Interface
- `ADDR_W`, default 64: address width on all ports.
- `DATA_W`, default 64: data width on all ports.
- `MASK_W`, default `DATA_W/8`: byte-write-mask width.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_address_in`  in  `ADDR_W`  fetch address.
- `instr_read_in`  in  1  fetch request, held until ready is seen.
- `instr_read_value_out`  out  `DATA_W`  fetched word, valid while `instr_ready_out`=1, then held.
- `instr_ready_out`  out  1  one-cycle completion pulse to fetch.
- `data_address_in`  in  `ADDR_W`  load/store address.
- `data_read_in`  in  1  load request, held until ready.
- `data_write_in`  in  1  store request, held until ready.
- `data_write_value_in`  in  `DATA_W`  store data.
- `data_write_mask_in`  in  `MASK_W`  store byte enables.
- `data_read_value_out`  out  `DATA_W`  load data, valid while `data_ready_out`=1, then held.
- `data_ready_out`  out  1  one-cycle completion pulse to the mem stage.
- `mem_address_out`  out  `ADDR_W`  registered bus address.
- `mem_read_out`  out  1  registered bus read strobe.
- `mem_write_out`  out  1  registered bus write strobe.
- `mem_write_value_out`  out  `DATA_W`  registered store data.
- `mem_write_mask_out`  out  `MASK_W`  registered byte enables.
- `mem_read_value_in`  in  `DATA_W`  memory read data, sampled when `mem_ready_in`=1.
- `mem_ready_in`  in  1  memory completion; may be high in the first BUSY cycle or any later one.

## Operation
- States:
  - IDLE: no transaction.
  - BUSY_I: instruction transaction on the bus.
  - BUSY_D: data transaction on the bus.
  - RESP_I: instruction response.
  - RESP_D: data response.
- A request is pending when:
  - instruction port: `instr_read_in`=1;
  - data port: `data_read_in` or `data_write_in` is 1.
- IDLE, one port pending: grant that port.
- IDLE, both pending: grant the port not granted last.
  - The `last_grant` register resets to "instruction", so data wins the first tie.
  - `last_grant` updates on every grant.
- On grant (IDLE→BUSY_x):
  - register the port's address, strobes, write value and mask into the `mem_*` outputs;
  - also latch address, read and write into a compare snapshot;
  - for an instruction grant, `mem_write_out`=0 and `mem_write_mask_out`=0.
- BUSY_x:
  - `mem_*` outputs are held constant;
  - inputs from the requesting port are ignored;
  - on `mem_ready_in`=1: capture `mem_read_value_in` into that port's read-value register, deassert `mem_read_out` and `mem_write_out`, go to RESP_x.
- RESP_x, ready pulse:
  - pulse `x_ready_out`=1 only if the port's current address, read and write equal the snapshot;
  - otherwise suppress the pulse; the request was withdrawn or changed by a flush.
- RESP_x always goes to IDLE next cycle. A changed or still-pending request is re-arbitrated there as a new transaction.
- A suppressed store still completed on the bus. The arbiter never cancels an issued transaction.
- The read-value register of the other port is never modified.
- `data_read_in` and `data_write_in` both high: both strobes are forwarded unchanged; the read value is captured as usual.
- Reset:
  - all outputs 0 (addresses, strobes, masks, write value, both read values, both readies);
  - state IDLE, `last_grant`=instruction;
  - an in-flight bus transaction is abandoned; the memory is reset by the same `reset`.

## Timing
- Request first seen in IDLE at cycle t:
  - `mem_*_out` valid from t+1;
  - `mem_ready_in` seen at t+k, k≥1;
  - `x_ready_out` high exactly at t+k+1;
  - IDLE at t+k+2.
- Minimum: request-to-ready 2 cycles; back-to-back transactions start every 3 cycles.
- Requester rule: a request, with its address and write data, stays stable until the cycle it sees ready. A new request may appear the cycle after ready.
- No combinational path from any input to any output; all outputs are registered.
- `x_read_value_out` updates on the same edge that raises `x_ready_out`, and holds until that port's next completion.

## Test plan
- Instruction read, addr `0x1000`, memory ready on first BUSY cycle returning `0xDEADBEEF00000013`:
  - `mem_read_out`=1, address `0x1000` at t+1;
  - `instr_ready_out` pulses at t+2 with that value;
  - IDLE at t+3.
- Store to `0x2008`, value `0x55`, mask `0x01`, memory ready after 4 cycles:
  - `mem_write_out` held 4 cycles with value and mask unchanged;
  - `data_ready_out` pulses once at t+5.
- Both ports request from reset:
  - grants in order data, instr, data;
  - no port starved; each ready pulse is routed only to its own port.
- Instruction request; fetch address changes from `0x40` to `0x80` mid-BUSY:
  - no `instr_ready_out` for the `0x40` transaction;
  - a new bus read of `0x80` starts 2 cycles after the `0x40` completion.
- `reset` asserted mid-BUSY_D:
  - all outputs 0 asynchronously;
  - after release, a held data request is re-issued from IDLE with `last_grant`=instruction.
- Memory ready stuck low for 100 cycles:
  - `mem_*` stable throughout;
  - no ready pulse on either port;
  - the pending instruction request is not granted.

Source files
------------

// File: rtl/cpu_bus_arbiter_if.sv
// Signal bundle between the CPU fetch/load-store ports,
// the arbiter and the shared memory bus.
interface cpu_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
);
    logic [ADDR_W-1:0] instr_address_in;
    logic              instr_read_in;
    logic [DATA_W-1:0] instr_read_value_out;
    logic              instr_ready_out;
    logic [ADDR_W-1:0] data_address_in;
    logic              data_read_in;
    logic              data_write_in;
    logic [DATA_W-1:0] data_write_value_in;
    logic [MASK_W-1:0] data_write_mask_in;
    logic [DATA_W-1:0] data_read_value_out;
    logic              data_ready_out;
    logic [ADDR_W-1:0] mem_address_out;
    logic              mem_read_out;
    logic              mem_write_out;
    logic [DATA_W-1:0] mem_write_value_out;
    logic [MASK_W-1:0] mem_write_mask_out;
    logic [DATA_W-1:0] mem_read_value_in;
    logic              mem_ready_in;

    // Arbiter view.
    modport slave (
        input  instr_address_in, instr_read_in,
        input  data_address_in, data_read_in, data_write_in,
        input  data_write_value_in, data_write_mask_in,
        input  mem_read_value_in, mem_ready_in,
        output instr_read_value_out, instr_ready_out,
        output data_read_value_out, data_ready_out,
        output mem_address_out, mem_read_out, mem_write_out,
        output mem_write_value_out, mem_write_mask_out
    );

    // CPU plus memory view.
    modport master (
        output instr_address_in, instr_read_in,
        output data_address_in, data_read_in, data_write_in,
        output data_write_value_in, data_write_mask_in,
        output mem_read_value_in, mem_ready_in,
        input  instr_read_value_out, instr_ready_out,
        input  data_read_value_out, data_ready_out,
        input  mem_address_out, mem_read_out, mem_write_out,
        input  mem_write_value_out, mem_write_mask_out
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Two-to-one instruction/data arbiter onto one memory bus,
// alternating priority, fully registered outputs.
module cpu_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int MASK_W = DATA_W / 8
) (
    input logic              clk,
    input logic              reset,
    cpu_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D
    } state_t;

    state_t state, state_d;

    // 1 = data port won the most recent grant.
    logic last_d;

    logic i_pend, d_pend, d_win;
    logic grant_i, grant_d;
    logic done_i, done_d;
    logic match_i, match_d;

    logic [ADDR_W-1:0] addr_q;
    logic              rd_q, wr_q;
    logic [DATA_W-1:0] wval_q;
    logic [MASK_W-1:0] mask_q;
    logic [DATA_W-1:0] i_rval_q, d_rval_q;
    logic              i_rdy_q, d_rdy_q;

    logic [ADDR_W-1:0] snap_addr;
    logic              snap_rd, snap_wr;

    // Arbitration, completion detection and next state.
    always_comb begin
        state_d = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done_i  = 1'b0;
        done_d  = 1'b0;
        i_pend  = bus.instr_read_in;
        d_pend  = bus.data_read_in | bus.data_write_in;
        d_win   = d_pend & (~i_pend | ~last_d);
        match_i = (bus.instr_address_in == snap_addr)
                & (bus.instr_read_in == snap_rd);
        match_d = (bus.data_address_in == snap_addr)
                & (bus.data_read_in == snap_rd)
                & (bus.data_write_in == snap_wr);
        unique case (state)
            IDLE: begin
                grant_d = d_win;
                grant_i = i_pend & ~d_win;
                if (grant_d)      state_d = BUSY_D;
                else if (grant_i) state_d = BUSY_I;
            end
            BUSY_I: begin
                done_i = bus.mem_ready_in;
                if (done_i) state_d = RESP_I;
            end
            BUSY_D: begin
                done_d = bus.mem_ready_in;
                if (done_d) state_d = RESP_D;
            end
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and priority history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state <= state_d;
            if (grant_d)      last_d <= 1'b1;
            else if (grant_i) last_d <= 1'b0;
        end
    end

    // Bus launch, snapshot, read capture and ready pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wval_q    <= '0;
            mask_q    <= '0;
            i_rval_q  <= '0;
            d_rval_q  <= '0;
            i_rdy_q   <= 1'b0;
            d_rdy_q   <= 1'b0;
            snap_addr <= '0;
            snap_rd   <= 1'b0;
            snap_wr   <= 1'b0;
        end else begin
            i_rdy_q <= 1'b0;
            d_rdy_q <= 1'b0;
            if (grant_i) begin
                addr_q    <= bus.instr_address_in;
                rd_q      <= 1'b1;
                wr_q      <= 1'b0;
                wval_q    <= '0;
                mask_q    <= '0;
                snap_addr <= bus.instr_address_in;
                snap_rd   <= 1'b1;
                snap_wr   <= 1'b0;
            end
            if (grant_d) begin
                addr_q    <= bus.data_address_in;
                rd_q      <= bus.data_read_in;
                wr_q      <= bus.data_write_in;
                wval_q    <= bus.data_write_value_in;
                mask_q    <= bus.data_write_mask_in;
                snap_addr <= bus.data_address_in;
                snap_rd   <= bus.data_read_in;
                snap_wr   <= bus.data_write_in;
            end
            if (done_i) begin
                i_rval_q <= bus.mem_read_value_in;
                rd_q     <= 1'b0;
                wr_q     <= 1'b0;
                i_rdy_q  <= match_i;
            end
            if (done_d) begin
                d_rval_q <= bus.mem_read_value_in;
                rd_q     <= 1'b0;
                wr_q     <= 1'b0;
                d_rdy_q  <= match_d;
            end
        end
    end

    assign bus.mem_address_out      = addr_q;
    assign bus.mem_read_out         = rd_q;
    assign bus.mem_write_out        = wr_q;
    assign bus.mem_write_value_out  = wval_q;
    assign bus.mem_write_mask_out   = mask_q;
    assign bus.instr_read_value_out = i_rval_q;
    assign bus.instr_ready_out      = i_rdy_q;
    assign bus.data_read_value_out  = d_rval_q;
    assign bus.data_ready_out       = d_rdy_q;
endmodule
